// File: rtl/counter.sv
// counter: loadable, enable-gated up-counter wrapping at UPPERLIMIT
module counter #(
  parameter int DATAWIDTH  = 5,
  parameter int UPPERLIMIT = 28
) (
  input  logic [DATAWIDTH-1:0] data_in,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 clk,
  input  logic                 load,
  output logic [DATAWIDTH-1:0] data_out
);
  localparam logic [DATAWIDTH-1:0] lim = DATAWIDTH'(UPPERLIMIT);
  logic [DATAWIDTH-1:0] nxt;
  // >= also covers the unreachable above-limit state, forcing it back to 0
  always_comb
    nxt = load ? ((data_in > lim) ? '0 : data_in)
        : en   ? ((data_out >= lim) ? '0 : data_out + DATAWIDTH'(1))
        : data_out;
  always_ff @(posedge clk or negedge clr)
    if (!clr) data_out <= '0;
    else      data_out <= nxt;
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed self-checking bench for counter (W=5, limit 28)
module tb_counter;
  logic       clk = 1'b0;
  logic       clr, en, load;
  logic [4:0] data_in, data_out;
  int checks = 0;
  int errors = 0;

  counter #(.DATAWIDTH(5), .UPPERLIMIT(28)) dut (
    .data_in(data_in), .en(en), .clr(clr), .clk(clk), .load(load), .data_out(data_out)
  );

  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; en = 1'b1; load = 1'b0; data_in = 5'd0;
    #1 check("reset_t0", data_out, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", data_out, 5'd0);
    end
    clr = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      check($sformatf("count_%0d", i), data_out, 5'(i % 29));
    end
    for (int i = 3; i <= 8; i++) tick();
    check("pre_reset", data_out, 5'd8);
    clr = 1'b0;
    #2 check("async_clear", data_out, 5'd0);
    clr = 1'b1;
    #1 check("after_release", data_out, 5'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("resume_%0d", i), data_out, 5'(i));
    end
    en = 1'b0;
    tick(); check("hold_en0", data_out, 5'd3);
    tick(); check("hold_en0_b", data_out, 5'd3);
    en = 1'b1;
    tick(); check("en_again", data_out, 5'd4);
    load = 1'b1; data_in = 5'd8;
    tick(); check("load8", data_out, 5'd8);
    tick(); check("load8_held", data_out, 5'd8);
    load = 1'b0;
    tick(); check("after_load_9", data_out, 5'd9);
    tick(); check("after_load_10", data_out, 5'd10);
    load = 1'b1; data_in = 5'd30;
    tick(); check("load30_bad", data_out, 5'd0);
    load = 1'b0;
    tick(); check("bad_resume_1", data_out, 5'd1);
    tick(); check("bad_resume_2", data_out, 5'd2);
    load = 1'b1; data_in = 5'd31;
    tick(); check("load31_bad", data_out, 5'd0);
    data_in = 5'd29;
    tick(); check("load29_bad", data_out, 5'd0);
    data_in = 5'd28; en = 1'b0;
    tick(); check("load28_en0", data_out, 5'd28);
    load = 1'b0; en = 1'b1;
    tick(); check("wrap_from_load", data_out, 5'd0);
    load = 1'b1; data_in = 5'd17;
    clr = 1'b0;
    tick(); check("reset_beats_load", data_out, 5'd0);
    clr = 1'b1;
    tick(); check("load17", data_out, 5'd17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
